// File: rtl/c16_rom_loader.sv
// ROM download sequencer: routes a 32 KB host image (BASIC then KERNAL) to the C16
// core's ROM write port, keeps the core in reset while loading, and gathers load statistics.
module c16_rom_loader #(
    parameter logic [7:0] ROM_INDEX   = 8'd0,
    parameter int         HOLD_CYCLES = 1024
) (
    input  logic        CLK28,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [13:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        basic_dl_write,
    output logic        kernal_dl_write,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  checksum,
    output logic [15:0] byte_count
);

    // state | meaning
    // IDLE  | waiting for a rising ioctl_download with a matching index
    // LOAD  | host streaming; bytes routed to BASIC/KERNAL, core held in reset
    // HOLD  | download finished; core kept in reset while the hold timer runs out
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        dl_prev_q, dl_prev_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [13:0] dl_addr_q, dl_addr_d;
    logic [7:0]  dl_data_q, dl_data_d;
    logic        basic_wr_q, basic_wr_d;
    logic        kernal_wr_q, kernal_wr_d;
    logic        core_reset_q, core_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [15:0] byte_count_q, byte_count_d;

    logic start;

    assign start = ioctl_download & ~dl_prev_q & (ioctl_index == ROM_INDEX);

    always_comb begin
        state_d      = state_q;
        dl_prev_d    = ioctl_download;
        hold_cnt_d   = hold_cnt_q;
        dl_addr_d    = dl_addr_q;
        dl_data_d    = dl_data_q;
        basic_wr_d   = 1'b0;
        kernal_wr_d  = 1'b0;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        checksum_d   = checksum_q;
        byte_count_d = byte_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    checksum_d   = 8'h00;
                    byte_count_d = 16'h0000;
                    overflow_d   = 1'b0;
                    done_d       = 1'b0;
                    core_reset_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end

            ST_LOAD: begin
                if (ioctl_wr) begin
                    if (ioctl_addr[15]) begin
                        overflow_d = 1'b1;
                    end else begin
                        // Bit 14 of the file offset selects KERNAL over BASIC.
                        dl_addr_d   = ioctl_addr[13:0];
                        dl_data_d   = ioctl_dout;
                        basic_wr_d  = ~ioctl_addr[14];
                        kernal_wr_d = ioctl_addr[14];
                        checksum_d  = checksum_q + ioctl_dout;
                        if (byte_count_q != 16'hFFFF) begin
                            byte_count_d = byte_count_q + 16'd1;
                        end
                    end
                end
                if (!ioctl_download) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_INIT;
                end
            end

            ST_HOLD: begin
                if (start) begin
                    // Restart without releasing the core: core_reset stays high.
                    state_d      = ST_LOAD;
                    checksum_d   = 8'h00;
                    byte_count_d = 16'h0000;
                    overflow_d   = 1'b0;
                    done_d       = 1'b0;
                end else if (hold_cnt_q == 16'd0) begin
                    state_d      = ST_IDLE;
                    core_reset_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                core_reset_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK28) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            dl_prev_q    <= 1'b0;
            hold_cnt_q   <= 16'h0000;
            dl_addr_q    <= 14'h0000;
            dl_data_q    <= 8'h00;
            basic_wr_q   <= 1'b0;
            kernal_wr_q  <= 1'b0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            checksum_q   <= 8'h00;
            byte_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            dl_prev_q    <= dl_prev_d;
            hold_cnt_q   <= hold_cnt_d;
            dl_addr_q    <= dl_addr_d;
            dl_data_q    <= dl_data_d;
            basic_wr_q   <= basic_wr_d;
            kernal_wr_q  <= kernal_wr_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            checksum_q   <= checksum_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign dl_addr         = dl_addr_q;
    assign dl_data         = dl_data_q;
    assign basic_dl_write  = basic_wr_q;
    assign kernal_dl_write = kernal_wr_q;
    assign core_reset      = core_reset_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign overflow        = overflow_q;
    assign checksum        = checksum_q;
    assign byte_count      = byte_count_q;

endmodule

// File: tb/tb_c16_rom_loader.sv
// Directed bench for c16_rom_loader: full image, hold timing, overflow, ignored
// downloads, back-to-back writes, restart during HOLD and reset mid-load.
module tb_c16_rom_loader;

    logic        clk;
    logic        rst;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [13:0] dl_addr;
    logic [7:0]  dl_data;
    logic        basic_dl_write;
    logic        kernal_dl_write;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  checksum;
    logic [15:0] byte_count;

    int n_tests = 0;
    int n_fail  = 0;

    c16_rom_loader #(.ROM_INDEX(8'd0), .HOLD_CYCLES(16)) dut (
        .CLK28          (clk),
        .RESET          (rst),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .basic_dl_write (basic_dl_write),
        .kernal_dl_write(kernal_dl_write),
        .core_reset     (core_reset),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .checksum       (checksum),
        .byte_count     (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
    endtask

    // Runs out HOLD within a cycle budget; an expired budget shows up as busy still high.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        int nb, nk, e_addr, e_data, e_idle, e_rst, n;
        logic [15:0] av;
        logic        cr_dropped;

        rst = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = 16'h0;
        ioctl_dout = 8'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_core_reset", 32'(core_reset), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_outputs", {dl_addr, dl_data, basic_dl_write, kernal_dl_write, overflow, checksum}, 0);
        chk("rst_byte_count", 32'(byte_count), 0);

        // Full image: one byte per two cycles, value = addr[7:0]
        ioctl_download = 1'b1;
        chk("full_pre_core_reset", 32'(core_reset), 0);
        tick();
        chk("full_core_reset_rise", 32'(core_reset), 1);
        chk("full_busy_rise", 32'(busy), 1);
        nb = 0; nk = 0; e_addr = 0; e_data = 0; e_idle = 0; e_rst = 0;
        for (int a = 0; a < 32768; a++) begin
            av = a[15:0];
            wr_byte(av, av[7:0]);
            tick();
            ioctl_wr = 1'b0;
            if (basic_dl_write) nb++;
            if (kernal_dl_write) nk++;
            if ({basic_dl_write, kernal_dl_write} != (av[14] ? 2'b01 : 2'b10)) e_addr++;
            else if (dl_addr != av[13:0]) e_addr++;
            if (dl_data != av[7:0]) e_data++;
            if (!core_reset) e_rst++;
            tick();
            if (basic_dl_write || kernal_dl_write) e_idle++;
        end
        chk("full_basic_strobes", nb, 16384);
        chk("full_kernal_strobes", nk, 16384);
        chk("full_strobe_sel_addr_errs", e_addr, 0);
        chk("full_data_errs", e_data, 0);
        chk("full_extra_strobes", e_idle, 0);
        chk("full_core_reset_low_in_load", e_rst, 0);
        chk("full_byte_count", 32'(byte_count), 32'h8000);
        chk("full_checksum", 32'(checksum), 0);
        chk("full_overflow", 32'(overflow), 0);

        // Hold timing: fall sampled at next edge, then exactly 16 cycles
        ioctl_download = 1'b0;
        tick();
        chk("hold_core_reset_after_fall", 32'(core_reset), 1);
        n = 0;
        while (core_reset && n < 100) begin
            tick();
            n++;
            if (core_reset != busy) e_rst++;
        end
        chk("hold_cycles", n, 16);
        chk("hold_busy_with_core_reset", e_rst, 0);
        chk("hold_busy_low", 32'(busy), 0);
        chk("full_done", 32'(done), 1);

        // Overflow
        ioctl_download = 1'b1;
        tick();
        chk("ovf_done_cleared", 32'(done), 0);
        chk("ovf_count_cleared", 32'(byte_count), 0);
        wr_byte(16'h7FFF, 8'h11);
        tick();
        chk("ovf_kernal_strobe", {basic_dl_write, kernal_dl_write}, 32'b01);
        chk("ovf_dl_addr", 32'(dl_addr), 32'h3FFF);
        chk("ovf_dl_data", 32'(dl_data), 32'h11);
        wr_byte(16'h8000, 8'h22);
        tick();
        ioctl_wr = 1'b0;
        chk("ovf_no_strobe", {basic_dl_write, kernal_dl_write}, 0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_byte_count", 32'(byte_count), 1);
        chk("ovf_checksum", 32'(checksum), 32'h11);
        ioctl_download = 1'b0;
        tick();
        wait_idle("ovf_wait_idle");
        chk("ovf_done", 32'(done), 1);
        chk("ovf_sticky", 32'(overflow), 1);

        // Wrong index plus IDLE writes
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        e_idle = 0; e_rst = 0;
        for (int i = 0; i < 6; i++) begin
            wr_byte(16'h0010 + 16'(i), 8'hA5);
            tick();
            ioctl_wr = 1'b0;
            if (basic_dl_write || kernal_dl_write) e_idle++;
            if (core_reset || busy) e_rst++;
        end
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        for (int i = 0; i < 3; i++) begin
            wr_byte(16'h4010, 8'h5A);
            tick();
            ioctl_wr = 1'b0;
            if (basic_dl_write || kernal_dl_write) e_idle++;
            if (core_reset || busy) e_rst++;
        end
        chk("wrongidx_strobes", e_idle, 0);
        chk("wrongidx_core_reset", e_rst, 0);
        chk("wrongidx_done_kept", 32'(done), 1);
        chk("wrongidx_count_kept", 32'(byte_count), 1);

        // Back-to-back writes, last one coincident with download falling
        ioctl_download = 1'b1;
        tick();
        wr_byte(16'h3FFE, 8'h01);
        tick();
        chk("b2b_0", {basic_dl_write, kernal_dl_write, 2'b00, dl_addr}, {2'b10, 2'b00, 14'h3FFE});
        wr_byte(16'h3FFF, 8'h02);
        tick();
        chk("b2b_1", {basic_dl_write, kernal_dl_write, 2'b00, dl_addr}, {2'b10, 2'b00, 14'h3FFF});
        wr_byte(16'h4000, 8'h03);
        tick();
        chk("b2b_2", {basic_dl_write, kernal_dl_write, 2'b00, dl_addr}, {2'b01, 2'b00, 14'h0000});
        wr_byte(16'h4001, 8'h04);
        ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        chk("b2b_3", {basic_dl_write, kernal_dl_write, 2'b00, dl_addr}, {2'b01, 2'b00, 14'h0001});
        chk("b2b_last_data", 32'(dl_data), 32'h04);
        chk("b2b_count", 32'(byte_count), 4);
        chk("b2b_checksum", 32'(checksum), 32'h0A);
        tick();
        chk("b2b_no_strobe_in_hold", {basic_dl_write, kernal_dl_write}, 0);
        chk("b2b_in_hold", {busy, core_reset, done}, 32'b110);

        // Restart during HOLD: core_reset must never drop
        cr_dropped = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!core_reset) cr_dropped = 1'b1;
        end
        ioctl_download = 1'b1;
        tick();
        if (!core_reset) cr_dropped = 1'b1;
        chk("restart_count_cleared", 32'(byte_count), 0);
        chk("restart_checksum_cleared", 32'(checksum), 0);
        wr_byte(16'h0123, 8'h7E);
        tick();
        ioctl_wr = 1'b0;
        if (!core_reset) cr_dropped = 1'b1;
        chk("restart_load_strobe", {basic_dl_write, kernal_dl_write, 2'b00, dl_addr}, {2'b10, 2'b00, 14'h0123});
        chk("restart_count", 32'(byte_count), 1);
        ioctl_download = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
            if (busy && !core_reset) cr_dropped = 1'b1;
        end
        chk("restart_core_reset_held", 32'(cr_dropped), 0);
        chk("restart_done", {busy, done}, 32'b01);

        // Empty download
        ioctl_download = 1'b1;
        tick();
        chk("empty_busy", 32'(busy), 1);
        ioctl_download = 1'b0;
        tick();
        chk("empty_in_hold", 32'(core_reset), 1);
        wait_idle("empty_wait_idle");
        chk("empty_done", 32'(done), 1);
        chk("empty_count", 32'(byte_count), 0);

        // Reset mid-LOAD
        ioctl_download = 1'b1;
        tick();
        wr_byte(16'h4567, 8'h99);
        tick();
        chk("midrst_pre_count", 32'(byte_count), 1);
        wr_byte(16'h0001, 8'h55);
        rst = 1'b1;
        ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        chk("midrst_outputs", {dl_addr, dl_data, basic_dl_write, kernal_dl_write, overflow, checksum}, 0);
        chk("midrst_status", {core_reset, busy, done}, 0);
        chk("midrst_count", 32'(byte_count), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_idle", {core_reset, busy, done}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c16_rom_loader.md
Name: c16_rom_loader

Overview:
- Download sequencer between the host data_io byte stream (ioctl_*) and the C16 core's ROM download port (dl_addr, dl_data, kernal_dl_write, basic_dl_write).
- Accepts one 32 KB image: BASIC at offsets 0x0000–0x3FFF, KERNAL at 0x4000–0x7FFF. Routes each byte to the correct ROM.
- Holds the core in reset during the download and for a fixed time after it.
- Reports byte count, checksum and overflow status.

Parameters:
- ROM_INDEX, 8'd0, ioctl_index value that selects this loader.
- HOLD_CYCLES, 1024, number of CLK28 cycles core_reset stays high after download ends; legal range 1..65535.

Ports:
- CLK28  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high while the host is streaming a file.
- ioctl_index  in  8  file type; sampled only on the rising edge of ioctl_download.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  16  byte offset within the file.
- ioctl_dout  in  8  byte value.
- dl_addr  out  14  ROM word address; goes to the core's dl_addr.
- dl_data  out  8  ROM data; goes to the core's dl_data.
- basic_dl_write  out  1  one-cycle write strobe to the BASIC ROM.
- kernal_dl_write  out  1  one-cycle write strobe to the KERNAL ROM.
- core_reset  out  1  ORed into the core's RESET input.
- busy  out  1  high in LOAD or HOLD.
- done  out  1  sticky; high after a completed load.
- overflow  out  1  sticky; a byte arrived at offset ≥ 0x8000 in the current load.
- checksum  out  8  mod-256 sum of accepted in-range bytes.
- byte_count  out  16  count of accepted in-range bytes; saturates at 0xFFFF.

Behaviour:
- **Reset.** RESET=1 forces state IDLE and sets every output to 0, including core_reset, hold counter and download edge-detect register. RESET takes priority over all other events, including mid-LOAD and mid-HOLD.
- **States:** IDLE, LOAD, HOLD.
- **Edge detect.** dl_prev <= ioctl_download every cycle. start = ioctl_download & ~dl_prev & (ioctl_index == ROM_INDEX).
- **IDLE**
  - start -> LOAD. Clear checksum, byte_count, overflow and done. Set core_reset=1 and busy=1 on the same edge.
  - Rising download with a non-matching index is ignored; the loader stays in IDLE.
  - ioctl_wr is ignored.
- **LOAD**
  - ioctl_wr in cycle n produces registered outputs in cycle n+1:
    - dl_addr = ioctl_addr[13:0], dl_data = ioctl_dout.
    - basic_dl_write = 1 when ioctl_addr[15:14] == 2'b00.
    - kernal_dl_write = 1 when ioctl_addr[15:14] == 2'b01.
    - At most one strobe is high, for exactly one cycle.
  - Offset ≥ 0x8000: no strobe, overflow <= 1. checksum and byte_count are unchanged.
  - In-range byte: checksum <= checksum + ioctl_dout (8-bit wrap). byte_count <= byte_count + 1, holding at 0xFFFF.
  - ioctl_wr on consecutive cycles is accepted every cycle; there is no backpressure.
  - dl_addr and dl_data hold their last values when no write occurs.
  - ioctl_download low -> HOLD, hold counter <= HOLD_CYCLES-1. A write strobe in that same cycle is still accepted.
- **HOLD**
  - core_reset=1. The counter decrements each cycle.
  - At 0 -> IDLE on the next edge: core_reset <= 0, busy <= 0, done <= 1.
  - A matching start during HOLD -> LOAD. Statistics are cleared and core_reset stays high continuously.
  - ioctl_wr is ignored.
- **Empty download** (download rises then falls with no ioctl_wr): full HOLD still occurs, done=1, byte_count=0.
- **Address use.** Offsets are taken from ioctl_addr, not from a local counter. Out-of-order or repeated addresses are written as given; repeats are counted twice.
- **Idle strobes.** Strobes are never asserted in IDLE or HOLD.

Test Plan:
- **Full image.** RESET, then download index 0 with 32768 bytes where value = addr[7:0], one per 2 cycles. Required:
  - 16384 basic_dl_write strobes, then 16384 kernal_dl_write strobes.
  - Each strobe's dl_addr = addr[13:0], and each strobe appears 1 cycle after its ioctl_wr.
  - byte_count = 0x8000, checksum = 0x00, overflow = 0, done = 1.
- **Reset hold timing** (HOLD_CYCLES=16). Required:
  - core_reset rises on the edge after ioctl_download rises.
  - core_reset stays high through the load and exactly 16 cycles after the fall edge is sampled, then drops; busy falls on the same cycle.
- **Overflow.** Write bytes at 0x7FFF (0x11) and 0x8000 (0x22). Required:
  - One kernal strobe with dl_addr = 0x3FFF, dl_data = 0x11.
  - No strobe for 0x8000.
  - overflow = 1, byte_count = 1, checksum = 0x11.
- **Wrong index / IDLE writes.** Download with index 1, plus ioctl_wr pulses while IDLE -> no strobes, core_reset = 0, done unchanged.
- **Back-to-back writes and last-cycle write.** ioctl_wr high for 4 consecutive cycles (0x3FFE..0x4001), with the final write coincident with download falling. Required:
  - Strobes in order: basic, basic, kernal, kernal, on 4 consecutive cycles.
  - The final write is accepted and the loader enters HOLD.
- **Reset mid-operation and restart.** Required:
  - RESET asserted mid-LOAD -> all outputs 0 on the next cycle and state IDLE.
  - Separately, a new matching download during HOLD -> core_reset never drops and the statistics clear.
